// File: rtl/cfg_pkg.sv
// Shared types and defaults for the connection-box bitstream loader.
package cfg_pkg;

   localparam int DEF_NUM_SEG  = 4;
   localparam int DEF_SEG_BITS = 80;
   localparam int DEF_TIMEOUT  = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_t;

   // Why a load was abandoned; NONE means keep going.
   typedef enum logic [1:0] {
      CAUSE_NONE,
      CAUSE_EARLY_DONE,
      CAUSE_TIMEOUT,
      CAUSE_ORDER
   } err_cause_t;

endpackage

// File: rtl/cfg_piso_stage.sv
// Segment staging register: filled a byte at a time, drained MSB-first.
module cfg_piso_stage
   import cfg_pkg::*;
#(
   parameter int SEG_BITS = DEF_SEG_BITS
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   input  logic       i_shift,
   output logic       o_msb
);

   logic [SEG_BITS-1:0] r_sreg;

   // Bytes enter at the LSB end so the first byte of a segment sits in the MSB once full.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         r_sreg <= '0;
      else if (i_load)
         r_sreg <= {r_sreg[SEG_BITS-9:0], i_byte};
      else if (i_shift)
         r_sreg <= {r_sreg[SEG_BITS-2:0], 1'b0};
   end

   assign o_msb = r_sreg[SEG_BITS-1];

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Buffers one segment of bytes, streams it serially to the CB chain and checks each done return.
module cfg_bitstream_loader
   import cfg_pkg::*;
#(
   parameter int NUM_SEG  = DEF_NUM_SEG,
   parameter int SEG_BITS = DEF_SEG_BITS,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_start,
   input  logic [7:0]         i_byte_in,
   input  logic               i_byte_valid,
   output logic               o_byte_ready,
   output logic               o_bit_out,
   output logic               o_prgm_b,
   output logic               o_cb_prgm_b,
   output logic               o_chain_in,
   input  logic [NUM_SEG-1:0] i_seg_done,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_error
);

   localparam int NBYTES = SEG_BITS / 8;
   localparam int BIT_W  = $clog2(SEG_BITS + 1);
   localparam int BYTE_W = $clog2(NBYTES + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam int IDX_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

   state_t             r_state, w_nstate;
   err_cause_t         w_cause;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic [BYTE_W-1:0]  r_byte_cnt;
   logic [TMO_W-1:0]   r_tmo_cnt;
   logic [IDX_W-1:0]   r_seg_idx;
   logic               r_byte_ready, r_prgm_b, r_cb_prgm_b, r_chain_in;
   logic               r_busy, r_done, r_error;
   logic               w_accept, w_shift, w_cur_done, w_hi_done, w_prog, w_msb;

   assign w_accept   = r_byte_ready & i_byte_valid;
   assign w_shift    = (r_state == ST_STREAM);
   assign w_cur_done = i_seg_done[r_seg_idx];
   assign w_prog     = (w_nstate == ST_FILL) || (w_nstate == ST_STREAM) || (w_nstate == ST_CHECK);

   // Any segment further down the chain than the current one reporting done is a sequencing fault.
   always_comb begin
      w_hi_done = 1'b0;
      for (int i = 0; i < NUM_SEG; i++)
         if (i > int'(r_seg_idx)) w_hi_done = w_hi_done | i_seg_done[i];
   end

   cfg_piso_stage #(.SEG_BITS(SEG_BITS)) u_piso (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_accept),
      .i_byte    (i_byte_in),
      .i_shift   (w_shift),
      .o_msb     (w_msb)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_nstate;
   end

   // Next-state logic; every fault funnels through w_cause into ERR.
   always_comb begin
      w_nstate = r_state;
      w_cause  = CAUSE_NONE;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR:
            if (i_start) w_nstate = ST_FILL;
         ST_FILL:
            if (w_accept && r_byte_cnt == BYTE_W'(NBYTES - 1)) w_nstate = ST_STREAM;
         ST_STREAM:
            if (w_cur_done)                                w_cause  = CAUSE_EARLY_DONE;
            else if (r_bit_cnt == BIT_W'(SEG_BITS - 1))    w_nstate = ST_CHECK;
         ST_CHECK:
            if (w_hi_done)                                 w_cause  = CAUSE_ORDER;
            else if (w_cur_done)
               w_nstate = (r_seg_idx == IDX_W'(NUM_SEG - 1)) ? ST_DONE : ST_FILL;
            else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1))     w_cause  = CAUSE_TIMEOUT;
         default:
            w_nstate = ST_IDLE;
      endcase
      if (w_cause != CAUSE_NONE) w_nstate = ST_ERR;
   end

   // Counters restart on every state change, so none of them can wrap.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_byte_cnt <= '0;
         r_bit_cnt  <= '0;
         r_tmo_cnt  <= '0;
      end else if (w_nstate != r_state) begin
         r_byte_cnt <= '0;
         r_bit_cnt  <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         if (w_accept)              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
         if (r_state == ST_STREAM)  r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
         if (r_state == ST_CHECK)   r_tmo_cnt  <= r_tmo_cnt + TMO_W'(1);
      end
   end

   // Segment index: rewound on a new start, advanced when a segment checks out.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         r_seg_idx <= '0;
      else if (r_state != ST_FILL && r_state != ST_STREAM && r_state != ST_CHECK && i_start)
         r_seg_idx <= '0;
      else if (r_state == ST_CHECK && w_nstate == ST_FILL)
         r_seg_idx <= r_seg_idx + IDX_W'(1);
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_byte_ready <= 1'b0;
         r_prgm_b     <= 1'b1;
         r_cb_prgm_b  <= 1'b0;
         r_chain_in   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_byte_ready <= (w_nstate == ST_FILL);
         r_prgm_b     <= !w_prog;
         r_cb_prgm_b  <= (w_nstate == ST_STREAM);
         r_chain_in   <= w_prog;
         r_busy       <= w_prog;
         r_done       <= (w_nstate == ST_DONE);
         r_error      <= (w_nstate == ST_ERR);
      end
   end

   assign o_byte_ready = r_byte_ready;
   assign o_bit_out    = w_msb;
   assign o_prgm_b     = r_prgm_b;
   assign o_cb_prgm_b  = r_cb_prgm_b;
   assign o_chain_in   = r_chain_in;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream feeder for the daisy-chained connection-box configuration segments.
- Accepts the configuration bitstream as bytes over a valid/ready handshake and buffers one full segment.
- Streams each segment serially, one bit per clock with no gaps, onto the shared serial config line. Drives the global and CB program strobes.
- Checks each segment's done return (its cb_prgm_b_out) and reports done or error to the host/boot controller.

Parameters:
NUM_SEG, 4, number of chained CB config segments
SEG_BITS, 80, config bits per segment; must be a multiple of 8
TIMEOUT, 15, max cycles to wait for a segment done after its last bit

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins programming
byte_in  in  8  bitstream byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts byte this cycle
bit_out  out  1  serial config bit to segment bit_in
prgm_b  out  1  global program strobe, low while programming
cb_prgm_b  out  1  CB shift enable, high only while streaming
chain_in  out  1  drives first segment's cb_prgm_b_in
seg_done  in  NUM_SEG  cb_prgm_b_out of each segment, in chain order
busy  out  1  programming in progress
done  out  1  all segments loaded
error  out  1  sequencing fault detected

Behaviour:
- Reset values, all outputs registered: prgm_b=1; cb_prgm_b=0; chain_in=0; bit_out=0; byte_ready=0; busy=0; done=0; error=0. Reset clears the state, all counters and the staging register.
- IDLE: start transitions to FILL. prgm_b=0, chain_in=1, busy=1, seg_idx=0, done/error cleared. start is ignored while busy=1.
- FILL:
  - byte_ready=1.
  - Each valid&ready byte is stored into the SEG_BITS staging register, first byte in the most significant position.
  - After SEG_BITS/8 bytes, byte_ready drops the following cycle and the state moves to STREAM.
  - byte_valid gaps only stall FILL.
- STREAM:
  - Runs exactly SEG_BITS consecutive cycles with cb_prgm_b=1. bit_out = staging MSB, then the register shifts left.
  - Each byte goes out bit 7 first; the first streamed bit ends deepest in the segment.
  - byte_ready=0.
  - If seg_done[seg_idx] rises before the last streamed cycle: go to ERR.
- CHECK:
  - cb_prgm_b=0.
  - Pass if seg_done[seg_idx]=1 within TIMEOUT cycles, and all seg_done above seg_idx are 0 (indices below may be 1).
  - On pass: if seg_idx=NUM_SEG-1 go to DONE, otherwise increment seg_idx and go to FILL.
  - On timeout or an out-of-order done: go to ERR.
- DONE: prgm_b=1, chain_in=0, busy=0, done=1 held until the next start.
- ERR: cb_prgm_b=0, prgm_b=1, busy=0, error=1 held until the next start (full restart) or reset.
- Latency: segment k's first bit appears 1 cycle after its last byte is accepted. With back-to-back bytes, total time is about NUM_SEG*(SEG_BITS/8 + SEG_BITS + ~2) cycles.
- Reset mid-operation: immediate return to IDLE values; segments are left partially loaded, and the host must restart.
- Counters: bit counter sized clog2(SEG_BITS+1) and byte counter clog2(SEG_BITS/8+1); neither wraps, as both are cleared on each state entry.

Decomposition:
- Shared package cfg_pkg:
  - state enum (IDLE, FILL, STREAM, CHECK, DONE, ERR);
  - default SEG_BITS and NUM_SEG constants;
  - error-cause codes (EARLY_DONE, TIMEOUT, ORDER).
- One natural sub-module: cfg_piso_stage, the SEG_BITS parallel-load/byte-load shift register with load and shift enables.
- The FSM and counters stay in the top module.

Test Plan:
- Bench has 4 behavioural 80-bit segment models chained. Stream 40 bytes 0x00..0x27 back-to-back -> each segment's contents match its 10 bytes (MSB-first); cb_prgm_b high exactly 80 cycles per segment; done=1; prgm_b returns to 1.
- byte_valid toggling 1/0 each cycle during FILL -> the bit stream is identical to the back-to-back case; cb_prgm_b has no gaps within a segment.
- Segment 2 model never asserts done -> error=1 exactly TIMEOUT+1 cycles after segment 2's last bit; cb_prgm_b=0; busy=0.
- Segment 1 model asserts done after 79 bits -> error=1 during STREAM; no further bytes accepted.
- reset_n low in the middle of segment 1 STREAM -> all outputs at reset values asynchronously. A subsequent start reloads correctly from segment 0.
- start pulsed during STREAM -> ignored (seg_idx, counters unchanged). start after DONE -> done clears and a new load begins.
